// File: rtl/asip_pkg.sv
// Shared types and default constants for the vector ASIP pipeline sequencer.
package asip_pkg;

  localparam int REG_W_DEF     = 4;
  localparam int WB_DEPTH_DEF  = 3;
  localparam int FLUSH_CYC_DEF = 2;
  localparam int CNT_W_DEF     = 16;

  typedef struct packed {
    logic                 v;
    logic [REG_W_DEF-1:0] dst;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_scoreboard.sv
// In-flight destination tracker: shift register of issued writes plus source match.
module hazard_scoreboard
  import asip_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins,
  input  logic [REG_W-1:0] ins_dst,
  input  logic [REG_W-1:0] src_a,
  input  logic             src_a_used,
  input  logic [REG_W-1:0] src_b,
  input  logic             src_b_used,
  output logic             hit_a,
  output logic             hit_b
);

  sb_entry_t slot [WB_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WB_DEPTH; i++) slot[i] <= '0;
    end else begin
      slot[0] <= ins ? sb_entry_t'{v: 1'b1, dst: ins_dst} : '0;
      for (int i = 1; i < WB_DEPTH; i++) slot[i] <= slot[i-1];
    end
  end

  // The last slot writes back this cycle and the register file is write-first.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < WB_DEPTH - 1; i++) begin
      hit_a = hit_a | (src_a_used & slot[i].v & (slot[i].dst == src_a));
      hit_b = hit_b | (src_b_used & slot[i].v & (slot[i].dst == src_b));
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-side sequencer: RAW stalls, post-jump flush, execute bubbles, stall statistics.
//   state | meaning
//   RUN   | no hazard last cycle, instructions issue freely
//   STALL | decode held on a RAW hazard, re-evaluated every cycle
//   FLUSH | fetch/decode invalidated for FLUSH_CYC cycles after a jump
module hazard_stall_ctrl
  import asip_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int WB_DEPTH  = WB_DEPTH_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_src_a,
  input  logic             dec_src_a_used,
  input  logic [REG_W-1:0] dec_src_b,
  input  logic             dec_src_b_used,
  input  logic [REG_W-1:0] dec_dst,
  input  logic             dec_wr_en,
  input  logic             dec_jump,
  output logic             stall_fd,
  output logic             bubble_ex,
  output logic             flush_fd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);

  hz_state_e       state;
  logic [FC_W-1:0] fcnt;
  logic            hit_a, hit_b;
  logic            in_flush, hazard, issue;

  assign in_flush = (state == FLUSH);
  assign hazard   = dec_valid & ~in_flush & (hit_a | hit_b);
  assign issue    = dec_valid & ~hazard & ~in_flush;

  hazard_scoreboard #(
    .REG_W   (REG_W),
    .WB_DEPTH(WB_DEPTH)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .ins       (issue & dec_wr_en),
    .ins_dst   (dec_dst),
    .src_a     (dec_src_a),
    .src_a_used(dec_src_a_used),
    .src_b     (dec_src_b),
    .src_b_used(dec_src_b_used),
    .hit_a     (hit_a),
    .hit_b     (hit_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      fcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN, STALL: begin
          if (hazard) begin
            state <= STALL;
          end else if (issue && dec_jump) begin
            state <= FLUSH;
            fcnt  <= FC_W'(FLUSH_CYC - 1);
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          if (fcnt == '0) state <= RUN;
          else            fcnt  <= fcnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign stall_fd  = hazard;
  assign bubble_ex = hazard | in_flush;
  assign flush_fd  = in_flush;

endmodule
